// File: rtl/hdb3_pkg.sv
// Shared HDB3 line-code definitions.
// Symbol encoding on the two-wire bipolar interface and the legal zero-run
// limit. The encoder and the decoder use the same constants.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  localparam int HDB3_MAX_ZERO_RUN = 3;
  localparam int HDB3_PIPE_DEPTH   = 4;

endpackage

// File: rtl/hdb3_decode.sv
// HDB3 decoder.
// Takes one bipolar symbol per enabled clock, finds V pulses by polarity
// violation, strips each V and its companion B pulse, and emits the NRZ bit
// stream four accepted symbols later. Line-code errors are flagged as the
// offending symbol is accepted.
//
// Ports:
//   Clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   En         symbol strobe; Hdb3_In accepted only while En=1
//   Hdb3_In    symbol: 01=+1, 10=-1, 00=0, 11=illegal
//   Data_Out   recovered NRZ bit, held between accepted symbols
//   Data_Valid one-cycle pulse, Data_Out is new
//   Code_Err   one-cycle pulse, the accepted symbol violates HDB3
module hdb3_decode
  import hdb3_pkg::*;
#(
  parameter int MAX_ZERO_RUN = HDB3_MAX_ZERO_RUN,
  parameter int PIPE_DEPTH   = HDB3_PIPE_DEPTH
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       En,
  input  logic [1:0] Hdb3_In,
  output logic       Data_Out,
  output logic       Data_Valid,
  output logic       Code_Err
);

  localparam int ZW = $clog2(MAX_ZERO_RUN + 2);
  localparam int FW = $clog2(PIPE_DEPTH + 1);
  localparam logic [ZW-1:0] ZRUN_LIM = ZW'(MAX_ZERO_RUN);
  localparam logic [ZW-1:0] ZRUN_SAT = ZW'(MAX_ZERO_RUN + 1);
  localparam logic [FW-1:0] FILL_SAT = FW'(PIPE_DEPTH);

  logic [PIPE_DEPTH-1:0] dly_p0;
  logic [PIPE_DEPTH-1:0] dly_nxt;
  logic                  last_p;
  logic                  have_p;
  logic [ZW-1:0]         zrun;
  logic [FW-1:0]         fill;

  logic is_pulse;
  logic pol;
  logic is_v;
  logic bit_dec;
  logic err;

  function automatic logic [ZW-1:0] zrun_inc(input logic [ZW-1:0] c);
    return (c == ZRUN_SAT) ? c : c + ZW'(1);
  endfunction

  function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] c);
    return (c == FILL_SAT) ? c : c + FW'(1);
  endfunction

  // Symbol classification and next delay-line contents
  always_comb begin
    is_pulse = (Hdb3_In == SYM_POS) || (Hdb3_In == SYM_NEG);
    pol      = (Hdb3_In == SYM_NEG);
    is_v     = is_pulse && have_p && (pol == last_p);
    bit_dec  = is_pulse && !is_v;
    // Zero-run fires only on the transition into the over-limit count, so a
    // long run of zeros produces one pulse rather than a stream of them.
    err      = (Hdb3_In == SYM_ILL)
            || (!is_pulse && (zrun == ZRUN_LIM))
            || (is_v && (dly_p0[0] || dly_p0[1]));
    dly_nxt  = {dly_p0[PIPE_DEPTH-2:0], bit_dec};
    // A V three symbols after a B means that B was a substitution pulse,
    // not data; it is sitting in the stage about to move to the last slot.
    if (is_v) dly_nxt[PIPE_DEPTH-1] = 1'b0;
  end

  // Delay line, polarity tracker, counters and output register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dly_p0     <= '0;
      last_p     <= 1'b0;
      have_p     <= 1'b0;
      zrun       <= '0;
      fill       <= '0;
      Data_Out   <= 1'b0;
      Data_Valid <= 1'b0;
      Code_Err   <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Code_Err   <= 1'b0;
      if (En) begin
        Data_Out   <= dly_p0[PIPE_DEPTH-1];
        dly_p0     <= dly_nxt;
        Data_Valid <= (fill == FILL_SAT);
        Code_Err   <= err;
        fill       <= fill_inc(fill);
        if (is_pulse) begin
          last_p <= pol;
          have_p <= 1'b1;
          zrun   <= '0;
        end else begin
          zrun   <= zrun_inc(zrun);
        end
      end
    end
  end

endmodule
